// File: rtl/tiny_core_sequencer_if.sv
// rtl/tiny_core_sequencer_if.sv - host/core signal bundle for the tiny core sequencer
// master: host pins plus core model (drives commands, breakpoint setup, pc_in)
// slave : sequencer (drives imem write port, core_run, core_clr, state_o, busy)
interface tiny_core_sequencer_if #(
  parameter int INST_W = 8,
  parameter int PC_W   = 4
) ();
  logic              cmd_stb;
  logic [1:0]        cmd_op;
  logic [INST_W-1:0] cmd_data;
  logic              brk_en;
  logic [PC_W-1:0]   brk_addr;
  logic [PC_W-1:0]   pc_in;
  logic              imem_we;
  logic [PC_W-1:0]   imem_waddr;
  logic [INST_W-1:0] imem_wdata;
  logic              core_run;
  logic              core_clr;
  logic [1:0]        state_o;
  logic              busy;

  modport master (
    output cmd_stb, cmd_op, cmd_data, brk_en, brk_addr, pc_in,
    input  imem_we, imem_waddr, imem_wdata, core_run, core_clr, state_o, busy
  );

  modport slave (
    input  cmd_stb, cmd_op, cmd_data, brk_en, brk_addr, pc_in,
    output imem_we, imem_waddr, imem_wdata, core_run, core_clr, state_o, busy
  );
endinterface

// File: rtl/tiny_core_sequencer.sv
// rtl/tiny_core_sequencer.sv - run-control and program-load sequencer for the tiny accumulator core
// clk, rst_n : system clock, asynchronous active-low reset
// bus.cmd_*  : asynchronous host command strobe, opcode and load byte
// bus.brk_*  : breakpoint enable and PC; bus.pc_in is the live core PC
// bus.imem_* : instruction memory write port, one strobe per loaded byte
// bus.core_run / core_clr : core advance enable and one-cycle soft clear
// bus.state_o / busy : current sequencer state and non-HALT flag
module tiny_core_sequencer #(
  parameter int IMEM_SZ = 16,
  parameter int INST_W  = 8,
  parameter int PC_W    = 4
) (
  input logic             clk,
  input logic             rst_n,
  tiny_core_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  localparam logic [1:0] OP_HALT = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_STEP = 2'd3;
  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(IMEM_SZ - 1);

  state_t            state;
  logic              stb_meta;
  logic              stb_sync;
  logic              stb_last;
  logic              stb_pulse;
  logic [1:0]        op_q;
  logic              pend;
  logic [PC_W-1:0]   cnt;
  logic              bp_mask;
  logic              we_q;
  logic              clr_q;
  logic [PC_W-1:0]   waddr_q;
  logic [INST_W-1:0] wdata_q;

  logic              bp_hit;
  logic              cmd_go;
  logic [1:0]        cmd_sel;

  // bp_mask suppresses the hit on the first RUN cycle so a resume from a
  // breakpoint executes the instruction it stopped on.
  assign bp_hit  = bus.brk_en && (bus.pc_in == bus.brk_addr) && !bp_mask;

  // A command pulse that landed during STEP is replayed from op_q in HALT.
  assign cmd_go  = stb_pulse || pend;
  assign cmd_sel = pend ? op_q : bus.cmd_op;

  assign bus.core_run   = ((state == ST_RUN) && !bp_hit) || (state == ST_STEP);
  assign bus.core_clr   = clr_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.state_o    = state;
  assign bus.busy       = (state != ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HALT;
      stb_meta  <= 1'b0;
      stb_sync  <= 1'b0;
      stb_last  <= 1'b0;
      stb_pulse <= 1'b0;
      op_q      <= 2'd0;
      pend      <= 1'b0;
      cnt       <= '0;
      bp_mask   <= 1'b0;
      we_q      <= 1'b0;
      clr_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      // Two-flop synchronizer, then a rising-edge detector registered into
      // stb_pulse; a held strobe yields exactly one pulse.
      stb_meta  <= bus.cmd_stb;
      stb_sync  <= stb_meta;
      stb_last  <= stb_sync;
      stb_pulse <= stb_sync && !stb_last;
      if (stb_pulse) begin
        op_q <= bus.cmd_op;
      end
      we_q  <= 1'b0;
      clr_q <= 1'b0;

      case (state)
        ST_HALT: begin
          pend <= 1'b0;
          if (cmd_go) begin
            case (cmd_sel)
              OP_LOAD: begin
                state <= ST_LOAD;
                cnt   <= '0;
              end
              OP_RUN: begin
                state   <= ST_RUN;
                bp_mask <= 1'b1;
              end
              OP_STEP: state <= ST_STEP;
              default: ;
            endcase
          end
        end

        ST_LOAD: begin
          // Every pulse is a data byte; the opcode is don't-care here.
          if (stb_pulse) begin
            we_q    <= 1'b1;
            waddr_q <= cnt;
            wdata_q <= bus.cmd_data;
          end
          if (we_q) begin
            cnt <= cnt + PC_W'(1);
            if (cnt == LAST_ADDR) begin
              state <= ST_HALT;
              clr_q <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          bp_mask <= 1'b0;
          // LOAD beats a coincident breakpoint; otherwise HALT or a hit stops.
          if (stb_pulse && (bus.cmd_op == OP_LOAD)) begin
            state <= ST_LOAD;
            cnt   <= '0;
          end else if ((stb_pulse && (bus.cmd_op == OP_HALT)) || bp_hit) begin
            state <= ST_HALT;
          end
        end

        ST_STEP: begin
          state <= ST_HALT;
          if (stb_pulse) begin
            pend <= 1'b1;
          end
        end

        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_core_sequencer.sv
// tb/tb_tiny_core_sequencer.sv - directed self-checking bench for tiny_core_sequencer
`timescale 1ns/1ps
module tb_tiny_core_sequencer;

  localparam logic [1:0] OP_HALT = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_STEP = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tiny_core_sequencer_if #(.INST_W(8), .PC_W(4)) bus ();

  tiny_core_sequencer #(.IMEM_SZ(16), .INST_W(8), .PC_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [3:0] pc_model = 4'd0;
  logic [3:0] pc_force = 4'd0;
  logic       pc_force_en = 1'b0;
  logic       model_clr = 1'b0;

  assign bus.pc_in = pc_force_en ? pc_force : pc_model;

  always @(posedge clk) begin : core_model
    logic adv;
    logic clr;
    adv = bus.core_run;
    clr = bus.core_clr | model_clr;
    #1;
    if (clr) pc_model = 4'd0;
    else if (adv) pc_model = pc_model + 4'd1;
  end

  int         we_cnt = 0;
  int         clr_cnt = 0;
  int         run_cnt = 0;
  logic [3:0] waddr_log [64];
  logic [7:0] wdata_log [64];
  logic [1:0] clr_state = 2'd3;

  always @(negedge clk) begin
    if (bus.imem_we && we_cnt < 64) begin
      waddr_log[we_cnt] = bus.imem_waddr;
      wdata_log[we_cnt] = bus.imem_wdata;
      we_cnt = we_cnt + 1;
    end
    if (bus.core_clr) begin
      clr_cnt = clr_cnt + 1;
      clr_state = bus.state_o;
    end
    if (bus.core_run) run_cnt = run_cnt + 1;
  end

  task automatic start_cmd(input logic [1:0] op, input logic [7:0] data);
    @(negedge clk);
    bus.cmd_op = op;
    bus.cmd_data = data;
    bus.cmd_stb = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic finish_cmd();
    bus.cmd_stb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
    start_cmd(op, data);
    finish_cmd();
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (bus.state_o !== 2'd0) $display("FAIL reset_state got %0d want 0", bus.state_o); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.core_run !== 1'b0) $display("FAIL reset_core_run got %0b want 0", bus.core_run); else n_pass++;
    n_total++; if (bus.imem_we !== 1'b0 || bus.core_clr !== 1'b0) $display("FAIL reset_we_clr got %0b%0b want 00", bus.imem_we, bus.core_clr); else n_pass++;
    n_total++; if (bus.imem_waddr !== 4'd0 || bus.imem_wdata !== 8'd0) $display("FAIL reset_waddr_wdata got %0h/%0h want 0/0", bus.imem_waddr, bus.imem_wdata); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load();
    logic [7:0] tbl [16];
    int we0;
    int clr0;
    tbl = '{8'h44, 8'h0F, 8'h21, 8'h3A, 8'h80, 8'h55, 8'hC3, 8'h7E,
            8'h01, 8'hFF, 8'h10, 8'h99, 8'h2B, 8'hE4, 8'h68, 8'h00};
    we0 = we_cnt;
    clr0 = clr_cnt;
    send_cmd(OP_LOAD, 8'hEE);
    n_total++; if (bus.state_o !== 2'd1) $display("FAIL load_enter got %0d want 1", bus.state_o); else n_pass++;
    n_total++; if (we_cnt !== we0) $display("FAIL load_cmd_no_write got %0d writes want 0", we_cnt - we0); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      send_cmd(2'(i), tbl[i]);
      if (i == 0) begin
        n_total++; if (bus.state_o !== 2'd1 || bus.core_run !== 1'b0) $display("FAIL load_byte0_state got %0d/%0b want 1/0", bus.state_o, bus.core_run); else n_pass++;
      end
    end
    n_total++; if (we_cnt - we0 !== 16) $display("FAIL load_write_count got %0d want 16", we_cnt - we0); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (waddr_log[we0 + i] !== 4'(i) || wdata_log[we0 + i] !== tbl[i])
        $display("FAIL load_write%0d got %0h:%0h want %0h:%0h", i, waddr_log[we0 + i], wdata_log[we0 + i], i, tbl[i]);
      else n_pass++;
    end
    n_total++; if (clr_cnt - clr0 !== 1) $display("FAIL load_clr_cycles got %0d want 1", clr_cnt - clr0); else n_pass++;
    n_total++; if (clr_state !== 2'd0) $display("FAIL load_clr_state got %0d want 0", clr_state); else n_pass++;
    n_total++; if (bus.state_o !== 2'd0 || bus.core_clr !== 1'b0) $display("FAIL load_done got %0d/%0b want 0/0", bus.state_o, bus.core_clr); else n_pass++;
  endtask

  task automatic test_strobe_latency();
    bus.brk_en = 1'b0;
    @(negedge clk);
    bus.cmd_op = OP_RUN;
    bus.cmd_stb = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      n_total++; if (bus.state_o !== 2'd0 || bus.core_run !== 1'b0) $display("FAIL latency_edge%0d got %0d/%0b want 0/0", e, bus.state_o, bus.core_run); else n_pass++;
    end
    @(posedge clk); #1;
    n_total++; if (bus.state_o !== 2'd2 || bus.core_run !== 1'b1) $display("FAIL latency_edge4 got %0d/%0b want 2/1", bus.state_o, bus.core_run); else n_pass++;
    @(negedge clk);
    bus.cmd_op = OP_HALT;
    repeat (16) @(negedge clk);
    n_total++; if (bus.state_o !== 2'd2) $display("FAIL held_strobe got %0d want 2", bus.state_o); else n_pass++;
    finish_cmd();
    n_total++; if (bus.state_o !== 2'd2) $display("FAIL held_strobe_release got %0d want 2", bus.state_o); else n_pass++;
    send_cmd(OP_HALT, 8'h00);
    n_total++; if (bus.state_o !== 2'd0 || bus.busy !== 1'b0 || bus.core_run !== 1'b0) $display("FAIL halt_cmd got %0d/%0b/%0b want 0/0/0", bus.state_o, bus.busy, bus.core_run); else n_pass++;
  endtask

  task automatic test_breakpoint();
    logic found;
    @(negedge clk); model_clr = 1'b1;
    @(negedge clk); model_clr = 1'b0;
    n_total++; if (bus.pc_in !== 4'd0) $display("FAIL bp_pc_start got %0d want 0", bus.pc_in); else n_pass++;
    bus.brk_en = 1'b1;
    bus.brk_addr = 4'd5;
    send_cmd(OP_RUN, 8'h00);
    n_total++; if (bus.pc_in !== 4'd3) $display("FAIL bp_pc_running got %0d want 3", bus.pc_in); else n_pass++;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.pc_in == 4'd5) found = 1'b1;
    end
    n_total++; if (found !== 1'b1) $display("FAIL bp_reach got pc %0d want 5", bus.pc_in); else n_pass++;
    n_total++; if (bus.core_run !== 1'b0 || bus.state_o !== 2'd2) $display("FAIL bp_comb_stop got %0b/%0d want 0/2", bus.core_run, bus.state_o); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.state_o !== 2'd0 || bus.pc_in !== 4'd5) $display("FAIL bp_halt got %0d/%0d want 0/5", bus.state_o, bus.pc_in); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (bus.pc_in !== 4'd5) $display("FAIL bp_hold got %0d want 5", bus.pc_in); else n_pass++;
    send_cmd(OP_RUN, 8'h00);
    n_total++; if (bus.pc_in !== 4'd8 || bus.state_o !== 2'd2) $display("FAIL bp_resume got %0d/%0d want 8/2", bus.pc_in, bus.state_o); else n_pass++;
    send_cmd(OP_HALT, 8'h00);
    n_total++; if (bus.pc_in !== 4'd13 || bus.state_o !== 2'd0) $display("FAIL bp_final got %0d/%0d want 13/0", bus.pc_in, bus.state_o); else n_pass++;
  endtask

  task automatic test_step();
    int run0;
    bus.brk_en = 1'b1;
    bus.brk_addr = 4'd13;
    run0 = run_cnt;
    for (int s = 0; s < 3; s++) begin
      start_cmd(OP_STEP, 8'h00);
      n_total++; if (bus.state_o !== 2'd3 || bus.core_run !== 1'b1) $display("FAIL step%0d_active got %0d/%0b want 3/1", s, bus.state_o, bus.core_run); else n_pass++;
      finish_cmd();
      n_total++; if (bus.state_o !== 2'd0 || bus.busy !== 1'b0) $display("FAIL step%0d_return got %0d/%0b want 0/0", s, bus.state_o, bus.busy); else n_pass++;
    end
    n_total++; if (run_cnt - run0 !== 3) $display("FAIL step_run_cycles got %0d want 3", run_cnt - run0); else n_pass++;
    n_total++; if (bus.pc_in !== 4'd0) $display("FAIL step_pc got %0d want 0", bus.pc_in); else n_pass++;
  endtask

  task automatic test_async_reset();
    bus.brk_en = 1'b0;
    send_cmd(OP_RUN, 8'h00);
    n_total++; if (bus.state_o !== 2'd2) $display("FAIL areset_pre got %0d want 2", bus.state_o); else n_pass++;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.state_o !== 2'd0 || bus.core_run !== 1'b0) $display("FAIL areset_now got %0d/%0b want 0/0", bus.state_o, bus.core_run); else n_pass++;
    n_total++; if (bus.imem_we !== 1'b0 || bus.busy !== 1'b0) $display("FAIL areset_we_busy got %0b/%0b want 0/0", bus.imem_we, bus.busy); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (bus.state_o !== 2'd0 || bus.core_run !== 1'b0) $display("FAIL areset_after got %0d/%0b want 0/0", bus.state_o, bus.core_run); else n_pass++;
  endtask

  task automatic test_precedence();
    int we0;
    pc_force = 4'd2;
    pc_force_en = 1'b1;
    bus.brk_en = 1'b1;
    bus.brk_addr = 4'd5;
    send_cmd(OP_RUN, 8'h00);
    n_total++; if (bus.state_o !== 2'd2 || bus.core_run !== 1'b1) $display("FAIL prec_run got %0d/%0b want 2/1", bus.state_o, bus.core_run); else n_pass++;
    @(negedge clk);
    bus.cmd_op = OP_LOAD;
    bus.cmd_data = 8'h00;
    bus.cmd_stb = 1'b1;
    repeat (3) @(posedge clk);
    #1 pc_force = 4'd5;
    #1;
    n_total++; if (bus.core_run !== 1'b0 || bus.state_o !== 2'd2) $display("FAIL prec_hit got %0b/%0d want 0/2", bus.core_run, bus.state_o); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.state_o !== 2'd1 || bus.core_run !== 1'b0) $display("FAIL prec_load_wins got %0d/%0b want 1/0", bus.state_o, bus.core_run); else n_pass++;
    finish_cmd();
    we0 = we_cnt;
    send_cmd(OP_HALT, 8'hA5);
    send_cmd(OP_RUN, 8'h3C);
    n_total++; if (we_cnt - we0 !== 2) $display("FAIL prec_writes got %0d want 2", we_cnt - we0); else n_pass++;
    n_total++; if (waddr_log[we0] !== 4'd0 || wdata_log[we0] !== 8'hA5) $display("FAIL prec_first_byte got %0h:%0h want 0:a5", waddr_log[we0], wdata_log[we0]); else n_pass++;
    n_total++; if (waddr_log[we0 + 1] !== 4'd1 || wdata_log[we0 + 1] !== 8'h3C) $display("FAIL prec_second_byte got %0h:%0h want 1:3c", waddr_log[we0 + 1], wdata_log[we0 + 1]); else n_pass++;
    n_total++; if (bus.state_o !== 2'd1) $display("FAIL prec_still_load got %0d want 1", bus.state_o); else n_pass++;
    pc_force_en = 1'b0;
  endtask

  initial begin
    bus.cmd_stb = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_data = 8'd0;
    bus.brk_en = 1'b0;
    bus.brk_addr = 4'd0;
    test_reset();
    test_load();
    test_strobe_latency();
    test_breakpoint();
    test_step();
    test_async_reset();
    test_precedence();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t passed %0d of %0d", $time, n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tiny_core_sequencer.md
Name: tiny_core_sequencer

Overview:
- Run-control and program-load controller for the tiny accumulator processor core.
- Accepts host commands from the external input pins through a strobe handshake.
- Writes 16 instruction bytes into the core's instruction memory, then gates core execution with halt, run, single-step and a PC breakpoint.
- Sits between the top-level pins and the core: drives the imem write port, a core clock-enable and a soft-clear pulse.

Parameters:
- IMEM_SZ, 16, instruction memory depth; load length in bytes.
- INST_W, 8, instruction width in bits.
- PC_W, 4, program counter / imem address width; must equal clog2(IMEM_SZ).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_stb  input  1  host command strobe, asynchronous to clk; rising edge = one command
- cmd_op  input  2  command: 0=HALT, 1=LOAD, 2=RUN, 3=STEP; host holds it stable 4 cycles after the cmd_stb rise
- cmd_data  input  INST_W  instruction byte used in LOAD state; same stability rule as cmd_op
- brk_en  input  1  breakpoint enable
- brk_addr  input  PC_W  breakpoint PC
- pc_in  input  PC_W  current core PC
- imem_we  output  1  imem write strobe, one cycle per byte
- imem_waddr  output  PC_W  imem write address
- imem_wdata  output  INST_W  imem write data
- core_run  output  1  core advance enable (pc, IR, acc, dmem update only when 1)
- core_clr  output  1  one-cycle synchronous clear of core pc/IR/acc
- state_o  output  2  0=HALT, 1=LOAD, 2=RUN, 3=STEP
- busy  output  1  state != HALT

Behaviour:
- Reset (async, rst_n low):
  - state=HALT; all outputs 0; synchronizer flops 0; load counter 0; bp_mask=0.
  - Deassertion mid-operation restarts cleanly in HALT; a partially loaded imem is not cleared.
- Strobe path:
  - cmd_stb passes through a 2-flop synchronizer plus an edge register.
  - stb_pulse is a one-cycle pulse, high on the 3rd rising clk edge after cmd_stb first samples high.
  - cmd_op and cmd_data are registered on the stb_pulse cycle.
  - The state transition appears on the following edge.
  - Level-held cmd_stb produces only one pulse.
- HALT:
  - core_run=0.
  - LOAD -> LOAD, load counter cleared.
  - RUN -> RUN, bp_mask set.
  - STEP -> STEP.
  - HALT -> no change.
- LOAD:
  - core_run=0; every stb_pulse is a data byte, and cmd_op is ignored.
  - The cycle after the pulse: imem_we=1, imem_waddr=counter, imem_wdata=registered cmd_data; then counter+1.
  - After the write at address IMEM_SZ-1: counter wraps to 0, state -> HALT, and core_clr=1 for exactly that one cycle (the HALT entry cycle).
- RUN:
  - bp_hit = brk_en & (pc_in==brk_addr) & ~bp_mask.
  - core_run = ~bp_hit (combinational).
  - bp_mask clears after the first RUN cycle, so resuming from a breakpoint executes that instruction.
  - bp_hit -> HALT next edge; the instruction at brk_addr is not advanced.
  - HALT command -> HALT.
  - LOAD command -> LOAD, counter 0.
  - RUN and STEP commands are ignored.
  - A simultaneous bp_hit and command resolves to HALT, except LOAD, which wins.
- STEP:
  - Lasts exactly one cycle with core_run=1; the breakpoint is ignored.
  - Then HALT.
  - A pulse arriving during STEP is processed in the following HALT cycle as if it arrived there.
- busy and state_o are registered, with no combinational path from inputs.
- Counter is PC_W bits; wrap is natural modulo IMEM_SZ.

Test Plan:
- Reset: rst_n low mid-RUN, without a clock edge -> state_o=0, core_run=0, imem_we=0 immediately.
- Load 16 bytes 0x44,0x0F,...,0x00 via 16 strobes:
  - imem_we pulses 16 times at addresses 0..15 with matching data.
  - After the last write: state_o=0 and core_clr high for 1 cycle.
- Strobe latency: cmd_stb rises, op=RUN:
  - stb_pulse on the 3rd edge; state_o=2 and core_run=1 on the 4th.
  - Holding cmd_stb high 20 cycles yields one command only.
- Breakpoint: brk_en=1, brk_addr=5, RUN from pc=0 with the core model incrementing pc:
  - core_run falls combinationally when pc_in=5; state_o=0 next edge.
  - Re-issuing RUN advances past pc 5.
- STEP: three STEP commands from HALT -> exactly three single-cycle core_run pulses; state_o returns to 0 each time.
- Precedence: LOAD command on the same cycle as bp_hit in RUN -> state_o=1, counter=0, core_run=0.
